// File: rtl/tti_tx_sequencer_pkg.sv
// Shared types and constants for the TTI TX sequencer.
//   tx_seq_state_e : sequencer FSM states (IDLE, FETCH, SEND, FLUSH)
//   BytesPerWord   : bytes carried by one TX data word
package i3c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        FLUSH = 2'd3
    } tx_seq_state_e;

    localparam int unsigned BytesPerWord = 4;

endpackage

// File: rtl/tti_tx_sequencer_if.sv
// Bus bundle between the TTI TX queues, the private-read byte consumer and
// the TX sequencer.
//   desc_*  : TX descriptor queue read side (valid/ready pop, head data)
//   data_*  : TX data queue read side (valid/ready pop, head data)
//   byte_*  : output byte stream (valid/ready, byte, last flag)
//   abort_i : controller terminated the read
//   busy_o, done_o, aborted_o : sequencer status
// Modport master is the sequencer side; slave is the queue/consumer side.
interface tti_tx_sequencer_if #(
    parameter int TxDescDataWidth = 32,
    parameter int TxDataWidth     = 32
);
    logic                       desc_rvalid_i;
    logic                       desc_rready_o;
    logic [TxDescDataWidth-1:0] desc_rdata_i;
    logic                       data_rvalid_i;
    logic                       data_rready_o;
    logic [TxDataWidth-1:0]     data_rdata_i;
    logic                       byte_valid_o;
    logic                       byte_ready_i;
    logic [7:0]                 byte_o;
    logic                       byte_last_o;
    logic                       abort_i;
    logic                       busy_o;
    logic                       done_o;
    logic                       aborted_o;

    modport master (
        input  desc_rvalid_i, desc_rdata_i, data_rvalid_i, data_rdata_i,
               byte_ready_i, abort_i,
        output desc_rready_o, data_rready_o, byte_valid_o, byte_o,
               byte_last_o, busy_o, done_o, aborted_o
    );

    modport slave (
        output desc_rvalid_i, desc_rdata_i, data_rvalid_i, data_rdata_i,
               byte_ready_i, abort_i,
        input  desc_rready_o, data_rready_o, byte_valid_o, byte_o,
               byte_last_o, busy_o, done_o, aborted_o
    );

endinterface

// File: rtl/tti_tx_sequencer.sv
// TTI TX sequencer: pops one descriptor at a time, pops the data words that
// carry its payload and streams the bytes LSB-first with a last flag. A read
// abort flushes the descriptor's remaining data words so the descriptor and
// data queues stay aligned for the next transfer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (master)  : queue pop ports, byte stream, abort and status
module tti_tx_sequencer
    import i3c_pkg::*;
#(
    parameter int TxDescDataWidth = 32,
    parameter int TxDataWidth     = 32,
    parameter int DescLenWidth    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    tti_tx_sequencer_if.master    bus
);

    tx_seq_state_e           state_q, state_d;
    logic [DescLenWidth-1:0] rem_q, rem_d;
    logic [DescLenWidth-2:0] words_left_q, words_left_d;
    logic [1:0]              idx_q, idx_d;
    logic [TxDataWidth-1:0]  word_q, word_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;

    logic                    desc_rready;
    logic                    data_rready;
    logic                    byte_valid;
    logic                    byte_last;
    logic                    byte_hs;

    logic [DescLenWidth-1:0] len_in;
    logic [DescLenWidth:0]   len_plus3;
    logic [DescLenWidth-2:0] words_in;
    logic                    unused_desc_bits;

    // Upper descriptor bits carry fields owned by other blocks.
    assign unused_desc_bits = ^bus.desc_rdata_i[TxDescDataWidth-1:DescLenWidth];

    // Word count rounds the byte length up; the extra bit absorbs the +3 carry
    // so a maximum-length descriptor still yields the right word count.
    assign len_in    = bus.desc_rdata_i[DescLenWidth-1:0];
    assign len_plus3 = {1'b0, len_in} + (DescLenWidth+1)'(3);
    assign words_in  = len_plus3[DescLenWidth:2];

    assign byte_hs = byte_valid & bus.byte_ready_i;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        words_left_d = words_left_q;
        idx_d        = idx_q;
        word_d       = word_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        desc_rready  = 1'b0;
        data_rready  = 1'b0;
        byte_valid   = 1'b0;
        byte_last    = 1'b0;

        unique case (state_q)
            IDLE: begin
                desc_rready = bus.desc_rvalid_i;
                if (desc_rready) begin
                    rem_d        = len_in;
                    words_left_d = words_in;
                    if (len_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            FETCH: begin
                data_rready = bus.data_rvalid_i;
                if (data_rready) begin
                    // A word popped alongside an abort is still consumed.
                    word_d       = bus.data_rdata_i;
                    words_left_d = words_left_q - (DescLenWidth-1)'(1);
                    idx_d        = 2'd0;
                    state_d      = bus.abort_i ? FLUSH : SEND;
                end else if (bus.abort_i) begin
                    state_d = FLUSH;
                end
            end

            SEND: begin
                byte_valid = 1'b1;
                byte_last  = (rem_q == DescLenWidth'(1));
                if (byte_hs) begin
                    rem_d = rem_q - DescLenWidth'(1);
                    idx_d = idx_q + 2'd1;
                    // A final byte accepted together with abort completes
                    // the descriptor normally.
                    if (rem_q == DescLenWidth'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (bus.abort_i) begin
                        state_d = FLUSH;
                    end else if (idx_q == 2'(BytesPerWord - 1)) begin
                        state_d = FETCH;
                    end
                end else if (bus.abort_i) begin
                    state_d = FLUSH;
                end
            end

            FLUSH: begin
                if (words_left_q == '0) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    data_rready = bus.data_rvalid_i;
                    if (data_rready) begin
                        words_left_d = words_left_q - (DescLenWidth-1)'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            words_left_q <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            words_left_q <= words_left_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Pop strobes follow the queue valids combinationally; masking with the
    // reset keeps them low while the queues are still presenting entries.
    assign bus.desc_rready_o = desc_rready & rst_ni;
    assign bus.data_rready_o = data_rready & rst_ni;
    assign bus.byte_valid_o  = byte_valid;
    assign bus.byte_o        = word_q[{idx_q, 3'b000} +: 8];
    assign bus.byte_last_o   = byte_last;
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.done_o        = done_q;
    assign bus.aborted_o     = aborted_q;

endmodule

// File: doc/tti_tx_sequencer.md
Name: tti_tx_sequencer

Overview:
- Controller that drains the TTI TX descriptor queue and TX data queue and turns them into a byte stream for the I3C target private-read path.
- For each descriptor it pops the payload length, pops the matching number of 32-bit data words, and emits bytes LSB-first with a last flag.
- On a controller-side read termination (abort) it flushes the rest of that descriptor's data words, so the queues stay aligned for the next transfer.

Parameters:
- TxDescDataWidth, 32, TX descriptor word width.
- TxDataWidth, 32, TX data word width; fixed at 4 bytes per word.
- DescLenWidth, 16, width of the byte-length field held in descriptor bits [DescLenWidth-1:0].

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- desc_rvalid_i  in  1  TX descriptor queue has an entry
- desc_rready_o  out  1  pop TX descriptor
- desc_rdata_i  in  TxDescDataWidth  TX descriptor head
- data_rvalid_i  in  1  TX data queue has an entry
- data_rready_o  out  1  pop TX data word
- data_rdata_i  in  TxDataWidth  TX data head
- byte_valid_o  out  1  output byte valid
- byte_ready_i  in  1  consumer accepts byte
- byte_o  out  8  output byte
- byte_last_o  out  1  final byte of descriptor; qualified by byte_valid_o
- abort_i  in  1  controller terminated the read; level or pulse
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse: descriptor completed normally
- aborted_o  out  1  one-cycle pulse: descriptor flush finished after abort

Behaviour:
Reset values:
- All outputs 0; state IDLE; len, words_left, idx and word registers 0.

State machine: IDLE, FETCH, SEND, FLUSH.

IDLE:
- desc_rready_o = desc_rvalid_i.
- On pop, latch rem = desc_rdata_i[DescLenWidth-1:0] and words_left = (rem+3)>>2, computed in DescLenWidth+1 bits and stored in DescLenWidth-1 bits.
- If rem == 0: pulse done_o next cycle and stay IDLE.
- Otherwise go to FETCH.
- abort_i is ignored in IDLE.

FETCH:
- data_rready_o = data_rvalid_i.
- On pop: latch the word, words_left--, idx = 0, go to SEND.
- data_rvalid_i low means wait; this is not an error.

SEND:
- byte_valid_o = 1; byte_o = word[8*idx +: 8]; byte_last_o = (rem == 1).
- On handshake: rem--, idx++.
  - If rem was 1: pulse done_o and go to IDLE.
  - Else if idx was 3: go to FETCH.
  - Else stay in SEND.
- Once asserted, byte_valid_o and byte_o stay stable until the handshake.

FLUSH:
- data_rready_o = data_rvalid_i.
- Each pop decrements words_left.
- When words_left == 0 (checked on entry or after a pop): pulse aborted_o and go to IDLE.

Abort handling:
- abort_i in FETCH or SEND goes to FLUSH next cycle, and byte_valid_o drops.
- If abort_i coincides with a byte handshake, the byte counts as transferred.
- If that byte was the last byte, the descriptor completes normally: done_o pulses, aborted_o does not.
- If abort_i coincides with a FETCH data pop, the word is consumed (words_left--) and the block then enters FLUSH.

Latency:
- Descriptor pop in cycle N, FETCH in N+1.
- With data available, the first byte_valid_o is in N+2.
- Steady state is 1 byte/cycle within a word and 1 bubble cycle per word boundary.

Other rules:
- At most one descriptor is in flight; no descriptor pop until the current one completes or finishes flushing.
- Descriptor bits above DescLenWidth are ignored by this block.

Decomposition:
- i3c_pkg holds the tx_seq_state_e enum (IDLE, FETCH, SEND, FLUSH) and the BytesPerWord = 4 constant.
- Single module, no sub-module.
- The queue pop ports connect directly to the TTI TX descriptor queue and TX data queue read sides.

Test Plan:
1. Desc len=5, data words 0x44332211 and 0x000000AA, byte_ready_i=1 → bytes 11,22,33,44,AA; byte_last_o only on AA; 2 data pops; done_o one pulse; busy_o returns to 0.
2. Desc len=0 → desc popped, no data pop, no byte_valid_o; done_o pulses one cycle later.
3. Desc len=8, byte_ready_i toggling every other cycle → 8 bytes in order; byte_o stable while stalled; 2 data pops.
4. Desc len=12, abort_i pulsed after the 2nd byte accepted → no further bytes; remaining 2 words popped in FLUSH; aborted_o pulses; a following desc len=1 with word 0x000000EE emits EE.
5. Desc len=4, abort_i asserted in the same cycle as the 4th byte handshake → done_o pulses, aborted_o stays 0, no extra pops.
6. rst_ni asserted mid-SEND (len=8, after 3 bytes) → all outputs 0 immediately; state IDLE after release; the next descriptor is processed from scratch.
